// File: rtl/pattern_window_detector_pkg.sv
// pwd_pkg: shared mode encodings and fill-counter width helper for pattern_window_detector
package pwd_pkg;
  localparam logic MODE_OVERLAP = 1'b0;
  localparam logic MODE_NON_OVERLAP = 1'b1;
  function automatic int fill_w(input int win);
    return $clog2(win + 1);
  endfunction
endpackage

// File: rtl/pattern_window_detector_if.sv
// pattern_window_detector_if: cfg/stream inputs and hit/match/count outputs; master drives, slave is the detector
interface pattern_window_detector_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  logic clr;
  logic cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic cfg_mode;
  logic in_valid;
  logic in_bit;
  logic hit_o;
  logic match_o;
  logic [CNT_W-1:0] hit_cnt;
  modport master (
    output clr, cfg_load, cfg_pattern, cfg_mask, cfg_mode, in_valid, in_bit,
    input hit_o, match_o, hit_cnt
  );
  modport slave (
    input clr, cfg_load, cfg_pattern, cfg_mask, cfg_mode, in_valid, in_bit,
    output hit_o, match_o, hit_cnt
  );
endinterface

// File: rtl/pattern_window_detector_bit_history.sv
// pwd_bit_history: WIN-bit sample shift register with saturating fill count; exposes post-shift tail and fill
module pwd_bit_history
  import pwd_pkg::*;
#(
  parameter int WIN = 4,
  parameter int PAT_W = 3,
  parameter int FW = fill_w(WIN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic acc,
  input  logic in_bit,
  input  logic drop_fill,
  output logic [PAT_W-1:0] tail,
  output logic [FW-1:0] fill_next
);
  logic [WIN-1:0] hist, hist_next;
  logic [FW-1:0] fill;
  assign hist_next = acc ? WIN'({hist, in_bit}) : hist;
  assign fill_next = acc & (fill != FW'(WIN)) ? fill + FW'(1) : fill;
  assign tail = hist_next[PAT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (acc) begin
      hist <= hist_next;
      fill <= drop_fill ? '0 : fill_next;
    end
  end
endmodule

// File: rtl/pattern_window_detector.sv
// pattern_window_detector: masked programmable serial pattern detector with window match and saturating hit counter
module pattern_window_detector
  import pwd_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int WIN = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101)
) (
  input logic clk,
  input logic rst_n,
  pattern_window_detector_if.slave bus
);
  localparam int DEPTH = WIN - PAT_W + 1;
  localparam int FW = fill_w(WIN);
  logic [PAT_W-1:0] pat, msk, tail;
  logic mode, wipe, acc, hit;
  logic [FW-1:0] fill_next;
  logic [DEPTH-1:0] hh;
  assign wipe = bus.clr | bus.cfg_load;
  assign acc = bus.in_valid & ~wipe;
  assign hit = acc & (fill_next >= FW'(PAT_W)) & ~|((tail ^ pat) & msk);
  assign bus.match_o = |hh;
  pwd_bit_history #(.WIN(WIN), .PAT_W(PAT_W)) u_hist (
    .clk(clk),
    .rst_n(rst_n),
    .clr(wipe),
    .acc(acc),
    .in_bit(bus.in_bit),
    .drop_fill(hit & (mode == MODE_NON_OVERLAP)),
    .tail(tail),
    .fill_next(fill_next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat <= RST_PAT;
      msk <= '1;
      mode <= MODE_OVERLAP;
    end else if (bus.cfg_load & ~bus.clr) begin
      pat <= bus.cfg_pattern;
      msk <= bus.cfg_mask;
      mode <= bus.cfg_mode;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh <= '0;
      bus.hit_o <= 1'b0;
      bus.hit_cnt <= '0;
    end else begin
      hh <= wipe ? '0 : acc ? DEPTH'({hh, hit}) : hh;
      bus.hit_o <= hit;
      bus.hit_cnt <= bus.clr ? '0 : bus.hit_cnt + CNT_W'(hit & ~&bus.hit_cnt);
    end
  end
endmodule
